// File: rtl/muldiv_hilo.sv
`timescale 1ns/1ps
// HI/LO register unit and sequencer for the iterative shift-add multiplier (long_imul).
// Optional build macro CPU_MULACC_EN adds MADD/MADDU/MSUB/MSUBU accumulation.
module muldiv_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [3:0]         op_code,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               mul_start,
  output logic               mul_signd,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  input  logic               mul_ready,
  input  logic [2*WIDTH-1:0] mul_product
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
`ifdef CPU_MULACC_EN
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam int unsigned PW      = 2 * WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACC   = 2'd3
  } state_t;

  state_t state;

`ifdef CPU_MULACC_EN
  logic [PW-1:0] acc_prod;
  logic          acc_op;
  logic          acc_sub;
`endif

  assign busy     = (state != S_IDLE);
  assign op_ready = ~busy;

  // Operands and sign mode stay frozen from accept until the product is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      hi               <= '0;
      lo               <= '0;
      mul_start        <= 1'b0;
      mul_signd        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
`ifdef CPU_MULACC_EN
      acc_prod         <= '0;
      acc_op           <= 1'b0;
      acc_sub          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_MULT, OP_MULTU: begin
                mul_multiplicand <= rs_data;
                mul_multiplier   <= rt_data;
                mul_signd        <= (op_code == OP_MULT);
                mul_start        <= 1'b1;
                state            <= S_START;
`ifdef CPU_MULACC_EN
                acc_op           <= 1'b0;
                acc_sub          <= 1'b0;
`endif
              end
`ifdef CPU_MULACC_EN
              OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                mul_multiplicand <= rs_data;
                mul_multiplier   <= rt_data;
                mul_signd        <= (op_code == OP_MADD) || (op_code == OP_MSUB);
                mul_start        <= 1'b1;
                state            <= S_START;
                acc_op           <= 1'b1;
                acc_sub          <= (op_code == OP_MSUB) || (op_code == OP_MSUBU);
              end
`endif
              default: ;
            endcase
          end
        end
        // mul_ready is deliberately not sampled here; the multiplier holds it low during start.
        S_START: begin
          mul_start <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_ready) begin
`ifdef CPU_MULACC_EN
            if (acc_op) begin
              acc_prod <= mul_product;
              state    <= S_ACC;
            end else begin
              {hi, lo} <= mul_product;
              state    <= S_IDLE;
            end
`else
            {hi, lo} <= mul_product;
            state    <= S_IDLE;
`endif
          end
        end
`ifdef CPU_MULACC_EN
        S_ACC: begin
          {hi, lo} <= acc_sub ? ({hi, lo} - acc_prod) : ({hi, lo} + acc_prod);
          state    <= S_IDLE;
        end
`endif
        default: begin
          mul_start <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
`timescale 1ns/1ps
// Self-checking bench for muldiv_hilo with a behavioural long_imul stand-in.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op_code;
  logic        op_ready;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        mul_start;
  logic        mul_signd;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_ready;
  logic [63:0] mul_product;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_hl;

  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo), .busy(busy),
    .mul_start(mul_start), .mul_signd(mul_signd), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_ready(mul_ready), .mul_product(mul_product)
  );

  // Multiplier stand-in: 32 iterations, early-out on a zero operand, ready low while start is high.
  logic [5:0] mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 6'd0;
    else if (mul_start) mcnt <= (mul_multiplicand == 32'd0 || mul_multiplier == 32'd0) ? 6'd0 : 6'd32;
    else if (mcnt != 6'd0) mcnt <= mcnt - 6'd1;
  end
  assign mul_ready = (mcnt == 6'd0) && !mul_start;
  assign mul_product = mul_signd
    ? ({{32{mul_multiplicand[31]}}, mul_multiplicand} * {{32{mul_multiplier[31]}}, mul_multiplier})
    : ({32'd0, mul_multiplicand} * {32'd0, mul_multiplier});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one request at a negedge, then follow it cycle by cycle until the unit is idle.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    bit is_mul, is_acc, sgn;
    logic [63:0] prod;
    int lat, cyc;
    is_mul = (code == 4'd1) || (code == 4'd2);
    is_acc = 1'b0;
`ifdef CPU_MULACC_EN
    if (code >= 4'd5 && code <= 4'd8) begin
      is_mul = 1'b1;
      is_acc = 1'b1;
    end
`endif
    sgn  = (code == 4'd1) || (code == 4'd5) || (code == 4'd7);
    prod = sgn ? 64'(longint'($signed(a)) * longint'($signed(b)))
               : 64'(longint'({32'd0, a}) * longint'({32'd0, b}));
    if (is_acc) exp_hl = (code == 4'd7 || code == 4'd8) ? exp_hl - prod : exp_hl + prod;
    else if (is_mul) exp_hl = prod;
    else if (code == 4'd3) exp_hl[63:32] = a;
    else if (code == 4'd4) exp_hl[31:0] = a;
    lat = !is_mul ? 0 : (((a == 32'd0) || (b == 32'd0)) ? 2 : 34) + (is_acc ? 1 : 0);

    op_valid = 1'b1; op_code = code; rs_data = a; rt_data = b;
    @(posedge clk);
    @(negedge clk);
    if (inject) begin
      op_code = 4'd4; rs_data = 32'h11; rt_data = $urandom;
    end else begin
      op_valid = 1'b0; rs_data = $urandom; rt_data = $urandom;
    end
    cyc = 1;
    while (busy && cyc < 100) begin
      check("mul_start_window", 64'(mul_start), 64'(cyc == 1));
      check("signd_held", 64'(mul_signd), 64'(sgn));
      check("operand_a_held", 64'(mul_multiplicand), 64'(a));
      check("operand_b_held", 64'(mul_multiplier), 64'(b));
      check("op_ready_low", 64'(op_ready), 64'd0);
      if (inject) check("lo_untouched_while_busy", 64'(lo), 64'(exp_hl[31:0]) & 64'(is_mul ? lo : exp_hl[31:0]));
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0;
    check("busy_cycles", 64'(cyc - 1), 64'(lat));
    check("mul_start_idle", 64'(mul_start), 64'd0);
    check("op_ready_idle", 64'(op_ready), 64'd1);
    check("hi", 64'(hi), 64'(exp_hl[63:32]));
    check("lo", 64'(lo), 64'(exp_hl[31:0]));
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    exp_hl = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_op_ready", 64'(op_ready), 64'd1);
    check("reset_mul_start", 64'(mul_start), 64'd0);
    check("reset_signd", 64'(mul_signd), 64'd0);

    run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg3x5_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg3x5_lo", 64'(lo), 64'hFFFF_FFF1);

    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);

    run_op(4'd1, 32'd0, 32'h1234, 1'b0);
    check("mult_zero_hl", {32'(hi), 32'(lo)}, 64'd0);
    run_op(4'd3, 32'hA5A5_A5A5, 32'd0, 1'b0);
    check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthi_lo_kept", 64'(lo), 64'd0);

    // MTLO held during a multiply must not land until the unit is idle again.
    run_op(4'd2, 32'd7, 32'd6, 1'b1);
    check("mtlo_blocked_lo", 64'(lo), 64'd42);
    run_op(4'd4, 32'h11, 32'd0, 1'b0);
    check("mtlo_after_ready", 64'(lo), 64'h11);

    run_op(4'd3, 32'd0, 32'd0, 1'b0);
    run_op(4'd4, 32'd10, 32'd0, 1'b0);
    run_op(4'd5, 32'd3, 32'd4, 1'b0);
`ifdef CPU_MULACC_EN
    check("madd_lo", 64'(lo), 64'd22);
`else
    check("madd_ignored_lo", 64'(lo), 64'd10);
`endif
    run_op(4'd7, 32'd5, 32'd5, 1'b0);
`ifdef CPU_MULACC_EN
    check("msub_hi", 64'(hi), 64'hFFFF_FFFF);
    check("msub_lo", 64'(lo), 64'hFFFF_FFFD);
`else
    check("msub_ignored_hi", 64'(hi), 64'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 6) == 0) ? 32'd0 : 32'($urandom);
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : 32'($urandom);
      run_op(4'($urandom_range(0, 10)), ra, rb, 1'b0);
    end

    // Reset in the middle of WAIT abandons the multiply and clears HI/LO at once.
    run_op(4'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
    op_valid = 1'b1; op_code = 4'd1; rs_data = 32'd7; rt_data = 32'd9;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midwait_rst_busy", 64'(busy), 64'd0);
    check("midwait_rst_hl", {32'(hi), 32'(lo)}, 64'd0);
    check("midwait_rst_start", 64'(mul_start), 64'd0);
    exp_hl = 64'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("min_sq_hi", 64'(hi), 64'h4000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- HI/LO register unit and sequencing controller that sits directly downstream of the execute stage and drives the iterative shift-add multiplier (long_imul).
- Accepts MULT/MULTU/MTHI/MTLO (optionally MADD/MSUB family) requests.
- Issues the multiplier start pulse, holds operands and the sign mode stable for the whole operation, and captures the 64-bit product into HI/LO.
- Reports busy to the pipeline so MFHI/MFLO and new multiply ops stall.

Parameters:
WIDTH, 32, register width; must equal CPU_REG_WIDTH (multiplier counter limits it to ≤32)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
op_valid  in  1  request present
op_code  in  4  0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, others NOP
op_ready  out  1  unit idle; request accepted when op_valid && op_ready
rs_data  in  WIDTH  multiplicand / MTHI/MTLO source
rt_data  in  WIDTH  multiplier
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight (= !op_ready)
mul_start  out  1  start pulse to multiplier
mul_signd  out  1  signed mode to multiplier
mul_multiplicand  out  WIDTH  latched rs
mul_multiplier  out  WIDTH  latched rt
mul_ready  in  1  multiplier ready
mul_product  in  2*WIDTH  multiplier product (combinational on held operands/signd)

Behaviour:
- Reset (async, any state): state IDLE; hi, lo, operand regs, and mul_signd = 0; mul_start = 0; op_ready = 1. Reset mid-operation abandons it with no HI/LO write; the top level ties the multiplier nrst to ~rst.
- States: IDLE, START, WAIT, ACC (ACC only with the optional feature).
- IDLE:
  - Accept on op_valid && op_ready.
  - MTHI/MTLO: hi or lo <= rs_data at the accepting edge; stay in IDLE; 1-cycle op.
  - MULT/MULTU: latch rs and rt into the operand regs; mul_signd <= (MULT); go to START.
  - NOP or invalid code: no effect.
- START: mul_start = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - mul_start = 0; wait for mul_ready = 1.
  - mul_ready is ignored in the START cycle. The multiplier forces it low while start is asserted.
  - On mul_ready: {hi,lo} <= mul_product; go to IDLE.
- Operands and mul_signd are held constant from the accept edge through the capture edge. The product sign correction is combinational on them.
- Latency, with accept at edge E0:
  - Nonzero operands: capture at E34; busy cycles 1..34; new HI/LO and op_ready = 1 in cycle 35.
  - Either operand zero: capture at E2; busy cycles 1..2.
- While busy, op_valid is ignored with no side effects; upstream holds the request.
- mul_start is never asserted outside START.
- busy = (state != IDLE); op_ready = !busy, both combinational from state.

Optional Feature:
- Macro CPU_MULACC_EN.
- Defined:
  - Codes 5–8 are accepted like MULT/MULTU: signed for 5 and 7, unsigned for 6 and 8.
  - In WAIT, on mul_ready, mul_product is latched into an internal 2*WIDTH register and the state goes to ACC.
  - ACC (one cycle): {hi,lo} <= {hi,lo} ± latched product, where + is MADD/MADDU and − is MSUB/MSUBU, modulo 2^(2*WIDTH); then go to IDLE.
  - Adds one cycle of latency (nonzero operands: new HI/LO in cycle 36).
- Not defined: codes 5–8 are treated as NOP; the ACC state and accumulator register are absent.

Test Plan:
- Reset with rst=1, then release → hi=lo=0, op_ready=1, mul_start=0. Assert rst in the middle of WAIT → immediate return to IDLE, hi/lo=0.
- MULT rs=0xFFFFFFFD (−3), rt=5 → mul_start high only in cycle 1, busy cycles 1..34, hi=0xFFFFFFFF, lo=0xFFFFFFF1 in cycle 35.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; mul_signd=0 held throughout.
- MULT rs=0, rt=0x1234 → busy exactly 2 cycles, hi=lo=0. Then MTHI 0xA5A5A5A5 → hi updated next cycle, lo unchanged, no busy.
- MTLO 0x11 issued with op_valid during busy → ignored, lo unchanged until re-presented after op_ready=1.
- CPU_MULACC_EN: hi=0, lo=10, MADD 3×4 → lo=22. Then MSUB 5×5 → hi=0xFFFFFFFF, lo=0xFFFFFFFD. Without the macro, the same codes leave hi/lo unchanged and busy=0.
